// File: rtl/tournament_predictor.sv
// tournament_predictor
//    N-lane tournament conditional-branch predictor: a gshare table, a bimodal
//    ("simple") table and a meta chooser, each PHT_ENTRIES x 2-bit saturating
//    counters, plus a speculative global history register.
//
//    Lookups are combinational from registered state. Each lane gets its own
//    history checkpoint, chained from the lanes before it; chaining stops after
//    the first valid lane predicted taken. One resolve per cycle trains the
//    tables, and a mispredict repairs the history from the resolving
//    branch's checkpoint.
//
//    Ports
//       clock, reset            clock; synchronous active-high reset
//       i_lookup_valid[N]       lane i holds a conditional branch
//       i_lookup_pc[N*32]       branch PCs, lane 0 oldest
//       o_lookup_taken[N]       final prediction per lane
//       o_lookup_gshare[N]      gshare counter MSB per lane
//       o_lookup_simple[N]      simple counter MSB per lane
//       o_lookup_bhr[N*HB]      history checkpoint used by each lane
//       i_resolve_*             one resolving branch (pc, checkpoint, outcome,
//                               its gshare/simple bits, mispredict flag)
//       o_perf_lookups[32]      (TP_PERF_CNT_EN only) lookups consumed
//       o_perf_mispredicts[32]  (TP_PERF_CNT_EN only) resolved mispredicts
//
//    Optional feature macro: TP_PERF_CNT_EN adds the two performance counters.

module tournament_predictor #(
   parameter int N           = 2,
   parameter int PHT_ENTRIES = 64,
   parameter int HIST_BITS   = 6
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N-1:0]              i_lookup_valid,
   input  logic [N*32-1:0]           i_lookup_pc,
   output logic [N-1:0]              o_lookup_taken,
   output logic [N-1:0]              o_lookup_gshare,
   output logic [N-1:0]              o_lookup_simple,
   output logic [N*HIST_BITS-1:0]    o_lookup_bhr,
   input  logic                      i_resolve_valid,
   input  logic [31:0]               i_resolve_pc,
   input  logic [HIST_BITS-1:0]      i_resolve_bhr,
   input  logic                      i_resolve_taken,
   input  logic                      i_resolve_gshare,
   input  logic                      i_resolve_simple,
   input  logic                      i_resolve_mispredict
`ifdef TP_PERF_CNT_EN
   ,
   output logic [31:0]               o_perf_lookups,
   output logic [31:0]               o_perf_mispredicts
`endif
);

   localparam int IDX_BITS = $clog2(PHT_ENTRIES);

   logic [1:0]           r_gshare_pht [PHT_ENTRIES];
   logic [1:0]           r_simple_pht [PHT_ENTRIES];
   logic [1:0]           r_meta_pht   [PHT_ENTRIES];
   logic [HIST_BITS-1:0] r_bhr;

   logic [HIST_BITS-1:0] w_h    [N+1];
   logic [IDX_BITS-1:0]  w_idx  [N];
   logic [IDX_BITS-1:0]  w_gidx [N];
   logic [N-1:0]         w_g;
   logic [N-1:0]         w_s;
   logic [N-1:0]         w_t;
   logic [N-1:0]         w_lane_live;
   logic                 w_stop;
   logic [IDX_BITS-1:0]  w_ridx;
   logic [IDX_BITS-1:0]  w_rgidx;
   logic                 w_unused_pc_bits;

   function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'b01;
      else    return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   // Truncating the concatenation keeps the youngest HIST_BITS bits, which
   // also covers HIST_BITS == 1 (result is just the new bit).
   function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h,
                                                     input logic b);
      return HIST_BITS'({h, b});
   endfunction

   // Only PC bits [IDX_BITS+1:2] index the tables.
   assign w_unused_pc_bits = ^{i_lookup_pc, i_resolve_pc};

   always_comb begin
      w_h[0]          = r_bhr;
      w_stop          = 1'b0;
      w_lane_live     = '0;
      w_g             = '0;
      w_s             = '0;
      w_t             = '0;
      o_lookup_taken  = '0;
      o_lookup_gshare = '0;
      o_lookup_simple = '0;
      o_lookup_bhr    = '0;
      for (int i = 0; i < N; i++) begin
         w_idx[i]  = i_lookup_pc[i*32+2 +: IDX_BITS];
         w_gidx[i] = w_idx[i] ^ IDX_BITS'(w_h[i]);
         w_g[i]    = r_gshare_pht[w_gidx[i]][1];
         w_s[i]    = r_simple_pht[w_idx[i]][1];
         w_t[i]    = r_meta_pht[w_idx[i]][1] ? w_g[i] : w_s[i];
         // A lane past the first predicted-taken one is on the wrong path:
         // it still reports a prediction but does not extend the history.
         w_lane_live[i] = i_lookup_valid[i] && !w_stop;
         w_h[i+1]       = w_lane_live[i] ? shift_in(w_h[i], w_t[i]) : w_h[i];
         if (w_lane_live[i] && w_t[i]) w_stop = 1'b1;
         if (i_lookup_valid[i]) begin
            o_lookup_taken[i]                         = w_t[i];
            o_lookup_gshare[i]                        = w_g[i];
            o_lookup_simple[i]                        = w_s[i];
            o_lookup_bhr[i*HIST_BITS +: HIST_BITS]    = w_h[i];
         end
      end
   end

   assign w_ridx  = i_resolve_pc[IDX_BITS+1:2];
   assign w_rgidx = w_ridx ^ IDX_BITS'(i_resolve_bhr);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int e = 0; e < PHT_ENTRIES; e++) begin
            r_gshare_pht[e] <= 2'b01;
            r_simple_pht[e] <= 2'b01;
            r_meta_pht[e]   <= 2'b01;
         end
         r_bhr <= '0;
      end else begin
         if (i_resolve_valid) begin
            r_gshare_pht[w_rgidx] <= sat_step(r_gshare_pht[w_rgidx], i_resolve_taken);
            r_simple_pht[w_ridx]  <= sat_step(r_simple_pht[w_ridx], i_resolve_taken);
            // The chooser only learns when the two components disagreed.
            if (i_resolve_gshare != i_resolve_simple)
               r_meta_pht[w_ridx] <= sat_step(r_meta_pht[w_ridx],
                                              i_resolve_gshare == i_resolve_taken);
         end
         if (i_resolve_valid && i_resolve_mispredict)
            r_bhr <= shift_in(i_resolve_bhr, i_resolve_taken);
         else
            r_bhr <= w_h[N];
      end
   end

`ifdef TP_PERF_CNT_EN
   logic [31:0] r_perf_lookups;
   logic [31:0] r_perf_mispredicts;
   logic [31:0] w_live_cnt;

   always_comb begin
      w_live_cnt = '0;
      for (int i = 0; i < N; i++) w_live_cnt = w_live_cnt + 32'(w_lane_live[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_perf_lookups     <= '0;
         r_perf_mispredicts <= '0;
      end else begin
         r_perf_lookups <= r_perf_lookups + w_live_cnt;
         if (i_resolve_valid && i_resolve_mispredict)
            r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
   end

   assign o_perf_lookups     = r_perf_lookups;
   assign o_perf_mispredicts = r_perf_mispredicts;
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
module tb_tournament_predictor;
   localparam int N    = 2;
   localparam int PHT  = 64;
   localparam int HB   = 6;
   localparam int IDXM = PHT - 1;
   localparam int HM   = (1 << HB) - 1;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    lookup_valid = '0;
   logic [N*32-1:0] lookup_pc = '0;
   logic [N-1:0]    o_lookup_taken, o_lookup_gshare, o_lookup_simple;
   logic [N*HB-1:0] o_lookup_bhr;
   logic            resolve_valid = 1'b0;
   logic [31:0]     resolve_pc = '0;
   logic [HB-1:0]   resolve_bhr = '0;
   logic            resolve_taken = 1'b0, resolve_gshare = 1'b0;
   logic            resolve_simple = 1'b0, resolve_mispredict = 1'b0;
`ifdef TP_PERF_CNT_EN
   logic [31:0]     o_perf_lookups, o_perf_mispredicts;
`endif

   always #5 clock = ~clock;

   tournament_predictor #(.N(N), .PHT_ENTRIES(PHT), .HIST_BITS(HB)) dut (
      .clock                (clock),
      .reset                (reset),
      .i_lookup_valid       (lookup_valid),
      .i_lookup_pc          (lookup_pc),
      .o_lookup_taken       (o_lookup_taken),
      .o_lookup_gshare      (o_lookup_gshare),
      .o_lookup_simple      (o_lookup_simple),
      .o_lookup_bhr         (o_lookup_bhr),
      .i_resolve_valid      (resolve_valid),
      .i_resolve_pc         (resolve_pc),
      .i_resolve_bhr        (resolve_bhr),
      .i_resolve_taken      (resolve_taken),
      .i_resolve_gshare     (resolve_gshare),
      .i_resolve_simple     (resolve_simple),
      .i_resolve_mispredict (resolve_mispredict)
`ifdef TP_PERF_CNT_EN
      ,
      .o_perf_lookups       (o_perf_lookups),
      .o_perf_mispredicts   (o_perf_mispredicts)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain integer counters and history.
   int        m_g [PHT];
   int        m_s [PHT];
   int        m_m [PHT];
   int        m_bhr;
   bit [31:0] m_pl, m_pm;
   int        e_t [N], e_g [N], e_s [N], e_h [N];
   int        e_next, e_cnt;

   typedef struct {
      logic [31:0] pc;
      int          bhr;
      bit          g, s, t;
   } rec_t;
   rec_t      hist_q[$];
   logic [31:0] pool [8];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int sat(int v);
      return (v < 0) ? 0 : ((v > 3) ? 3 : v);
   endfunction

   task automatic model_reset();
      for (int e = 0; e < PHT; e++) begin
         m_g[e] = 1; m_s[e] = 1; m_m[e] = 1;
      end
      m_bhr = 0; m_pl = 0; m_pm = 0;
   endtask

   function automatic void model_lookup();
      int  h = m_bhr;
      bit  seen = 0;
      e_cnt = 0;
      for (int i = 0; i < N; i++) begin
         int idx = int'((lookup_pc[i*32 +: 32] >> 2) & IDXM);
         bit g = m_g[idx ^ h] >= 2;
         bit s = m_s[idx] >= 2;
         bit t = (m_m[idx] >= 2) ? g : s;
         if (lookup_valid[i]) begin
            e_t[i] = t; e_g[i] = g; e_s[i] = s; e_h[i] = h;
         end else begin
            e_t[i] = 0; e_g[i] = 0; e_s[i] = 0; e_h[i] = 0;
         end
         if (lookup_valid[i] && !seen) begin
            h = ((h << 1) | t) & HM;
            e_cnt++;
            if (t) seen = 1;
         end
      end
      e_next = h;
   endfunction

   task automatic model_commit();
      if (reset) begin
         model_reset();
         return;
      end
      if (resolve_valid) begin
         int ri = int'((resolve_pc >> 2) & IDXM);
         int gi = ri ^ int'(resolve_bhr);
         int d  = resolve_taken ? 1 : -1;
         m_g[gi] = sat(m_g[gi] + d);
         m_s[ri] = sat(m_s[ri] + d);
         if (resolve_gshare != resolve_simple)
            m_m[ri] = sat(m_m[ri] + ((resolve_gshare == resolve_taken) ? 1 : -1));
      end
      if (resolve_valid && resolve_mispredict)
         m_bhr = ((int'(resolve_bhr) << 1) | resolve_taken) & HM;
      else
         m_bhr = e_next;
      m_pl = m_pl + e_cnt;
      if (resolve_valid && resolve_mispredict) m_pm = m_pm + 1;
   endtask

   task automatic compare_model();
      model_lookup();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("lane%0d_taken", i),  o_lookup_taken[i],  e_t[i]);
         chk($sformatf("lane%0d_gshare", i), o_lookup_gshare[i], e_g[i]);
         chk($sformatf("lane%0d_simple", i), o_lookup_simple[i], e_s[i]);
         chk($sformatf("lane%0d_bhr", i),    o_lookup_bhr[i*HB +: HB], e_h[i]);
      end
`ifdef TP_PERF_CNT_EN
      chk("perf_lookups",     o_perf_lookups,     m_pl);
      chk("perf_mispredicts", o_perf_mispredicts, m_pm);
`endif
   endtask

   task automatic drive(logic [1:0] v, logic [31:0] p0, logic [31:0] p1,
                        logic rv, logic [31:0] rpc, logic [HB-1:0] rb,
                        logic rt, logic rg, logic rs, logic rm);
      lookup_valid       = v;
      lookup_pc          = {p1, p0};
      resolve_valid      = rv;
      resolve_pc         = rpc;
      resolve_bhr        = rb;
      resolve_taken      = rt;
      resolve_gshare     = rg;
      resolve_simple     = rs;
      resolve_mispredict = rm;
      #2;
      compare_model();
   endtask

   task automatic tick();
      model_commit();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Initial reset edge; model starts from the reset state.
      @(posedge clock);
      #1;
      model_reset();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;

      // 1: reset state lookup
      drive(2'b11, 32'h100, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_taken", o_lookup_taken, 2'b00);
      chk("t1_bhr0", o_lookup_bhr[5:0], 0);
      chk("t1_bhr1", o_lookup_bhr[11:6], 0);
      tick();

      // 2: train pc 0x100 taken twice with mispredict repair
      drive(2'b01, 32'h100, 0, 1, 32'h100, 6'd0, 1, 0, 0, 1);
      chk("t2_bhr_after_t1", o_lookup_bhr[5:0], 0);
      tick();
      drive(2'b01, 32'h100, 0, 1, 32'h100, 6'd0, 1, 0, 0, 1);
      chk("t2_bhr_repaired", o_lookup_bhr[5:0], 6'b000001);
      tick();
      drive(2'b01, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_taken", o_lookup_taken[0], 1);
      chk("t2_simple", o_lookup_simple[0], 1);
      chk("t2_bhr", o_lookup_bhr[5:0], 6'b000001);
      tick();

      // 3: first-taken truncation (history now 3)
      drive(2'b00, 0, 0, 1, 32'h200, 6'd0, 1, 1, 1, 0);
      tick();
      drive(2'b11, 32'h200, 32'h300, 0, 0, 0, 0, 0, 0, 0);
      chk("t3_lane0_taken", o_lookup_taken[0], 1);
      chk("t3_lane0_bhr", o_lookup_bhr[5:0], 6'd3);
      chk("t3_lane1_bhr", o_lookup_bhr[11:6], 6'd7);
      tick();

      // 4: mispredict repair overrides speculation
      drive(2'b01, 32'h100, 0, 1, 32'h104, 6'b101010, 0, 0, 0, 1);
      chk("t4_bhr_trunc", o_lookup_bhr[5:0], 6'd7);
      chk("t4_taken", o_lookup_taken[0], 1);
      tick();
      drive(2'b01, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4_bhr_repair", o_lookup_bhr[5:0], 6'b010100);
      tick();

      // 5: meta trains toward gshare and saturates
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 0, 0, 1, 32'h108, 6'd0, 1, 1, 0, (k == 3));
         tick();
      end
      drive(2'b11, 32'h108, 32'h108, 0, 0, 0, 0, 0, 0, 0);
      chk("t5_taken", o_lookup_taken, 2'b10);
      chk("t5_gshare", o_lookup_gshare, 2'b10);
      chk("t5_simple", o_lookup_simple, 2'b11);
      chk("t5_bhr0", o_lookup_bhr[5:0], 6'd1);
      chk("t5_bhr1", o_lookup_bhr[11:6], 6'd2);
      tick();

      // Randomized traffic against the model, with one mid-run reset.
      for (int k = 0; k < 8; k++) pool[k] = {22'($urandom), 8'($urandom_range(0, 63)), 2'b00};
      for (int c = 0; c < 3000; c++) begin
         logic [1:0]  v;
         logic [31:0] p0, p1, rpc;
         logic        rv, rt, rg, rs, rm;
         logic [HB-1:0] rb;
         reset = (c >= 1500 && c < 1502);
         v  = 2'($urandom);
         p0 = pool[$urandom_range(0, 7)];
         p1 = pool[$urandom_range(0, 7)];
         rt = 1'($urandom);
         if (hist_q.size() > 0 && $urandom_range(0, 9) < 7) begin
            rec_t r = hist_q.pop_front();
            rv = 1; rpc = r.pc; rb = HB'(r.bhr); rg = r.g; rs = r.s;
            rm = (rt != r.t);
         end else begin
            rv  = ($urandom_range(0, 3) == 0);
            rpc = pool[$urandom_range(0, 7)];
            rb  = HB'($urandom);
            rg  = 1'($urandom); rs = 1'($urandom); rm = 1'($urandom);
         end
         drive(v, p0, p1, rv, rpc, rb, rt, rg, rs, rm);
         if (v[0] && hist_q.size() < 16)
            hist_q.push_back('{pc: p0, bhr: e_h[0], g: e_g[0] != 0, s: e_s[0] != 0, t: e_t[0] != 0});
         tick();
      end
      reset = 1'b0;

`ifdef TP_PERF_CNT_EN
      // 6: performance counters after a fresh reset
      reset = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(2'b11, 32'h10, 32'h14, (k < 2), 32'h80, 6'd0, 0, 0, 0, 1);
         tick();
      end
      drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_perf_lookups", o_perf_lookups, 32'd6);
      chk("t6_perf_mispredicts", o_perf_mispredicts, 32'd2);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
